cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
// Execution controller for the 16-bit single-cycle CPU on the DE2 board. Generates a one-cycle
// clock-enable pulse (oCPU_CE) in the iCLK domain, so PC, register file and ParallelOUT advance
// only on that pulse. Supports single-step from a pushbutton and free-running at a programmable rate.
// Supports PC breakpoint and halt-instruction stop. Exports state and a step counter for LEDs/LCD.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  consecutive equal samples to accept a key level (10 ms at 50 MHz)
// DIV_W            26      width of iRATE_DIV and the run prescaler
// PC_W             16      width of iPC / iBP_ADDR
// CNT_W            16      width of oSTEP_CNT
// PORTS
// iCLK        in   1      system clock (CLOCK_50)
// iRST_N      in   1      asynchronous active-low reset
// iSTEP_KEY   in   1      raw pushbutton, active-low (pressed = 0), asynchronous
// iRUN        in   1      run switch level, asynchronous; 1 = free-run
// iRATE_DIV   in   DIV_W  iCLK cycles per CPU step in RUN; 0 treated as 1
// iBP_EN      in   1      breakpoint enable
// iBP_ADDR    in   PC_W   breakpoint PC
// iPC         in   PC_W   current CPU PC
// iHALT_INST  in   1      control unit decodes current instruction as HALT
// oCPU_CE     out  1      CPU clock enable, single-cycle pulse
// oSTATE      out  2      00 IDLE, 01 STEP, 10 RUN, 11 BREAK
// oSTEP_CNT   out  CNT_W  number of CE pulses issued since reset
// oBREAK      out  1      1 while in BREAK
// BEHAVIOUR
// - Reset (async): state IDLE, oCPU_CE=0, oSTEP_CNT=0, prescaler=0, debounce cnt=0. Key sync/debounced level=1; run sync=0.
// - Inputs: 2-flop synchronizers on iSTEP_KEY and iRUN. Key debounced: debounced level updates after DEBOUNCE_CYCLES
//   consecutive samples differing from it; any matching sample clears the count. press = debounced 1->0, 1-cycle event.
//   iRUN synchronized only (no debounce).
// - All outputs registered. oCPU_CE=1 exactly in cycles where the registered pulse flag is set; never two consecutive cycles.
// - Halt block: no pulse is ever issued while iHALT_INST=1; only reset exits a halted CPU.
// - IDLE: run_s=1 -> RUN (prescaler cleared); else press -> STEP. Both same cycle: RUN wins, press dropped.
// - STEP: issue one pulse (unless iHALT_INST), return to IDLE next cycle. Breakpoint not checked in STEP.
// - RUN: prescaler counts 0..D-1, D=max(iRATE_DIV,1); at count D-1 it wraps to 0 and a pulse is due.
//   When due: if iBP_EN && iPC==iBP_ADDR -> BREAK, no pulse; else if iHALT_INST -> BREAK, no pulse; else pulse.
//   First pulse after entering RUN comes D cycles after entry. run_s=0 -> IDLE immediately, pending pulse cancelled.
//   iRATE_DIV changed mid-run: if prescaler >= new D-1, pulse due next cycle, then normal period. press ignored in RUN.
// - BREAK: run_s=0 -> IDLE. press -> one pulse bypassing breakpoint compare (halt block still applies);
//   then RUN if run_s=1, else IDLE. run_s=0 and press same cycle: IDLE, no pulse.
// - Pulse latency: press event at cycle t -> oCPU_CE high at t+1 (from IDLE or BREAK).
// - oSTEP_CNT increments on every pulse; wraps 2^CNT_W-1 -> 0.
// - Reset mid-pulse: oCPU_CE drops asynchronously; no partial step counted.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
// - Reset, key held 1, iRUN=0 for 100 cycles -> oSTATE=00, oCPU_CE never 1, oSTEP_CNT=0.
// - Key low 2 cycles (bounce) then high -> no pulse; key low 10 cycles -> exactly one 1-cycle pulse, oSTEP_CNT=1.
// - iRUN=1, iRATE_DIV=5, iBP_EN=0 -> pulses every 5 cycles, first 5 cycles after RUN entry; 20 pulses -> oSTEP_CNT=20.
// - iRATE_DIV=0 -> pulse every other cycle; never two consecutive CE cycles.
// - RUN, iBP_EN=1, iBP_ADDR=16'h0007, iPC advancing 5,6,7 -> pulses at PC 5 and 6 only, oSTATE=11, oBREAK=1.
// - Key press in BREAK -> one pulse while iPC=7, resumes RUN.
// - iHALT_INST=1 in RUN -> BREAK, no pulse; key press in STEP/BREAK with halt -> no pulse.
// - Async iRST_N low during RUN mid-count -> oCPU_CE=0, oSTATE=00, oSTEP_CNT=0 immediately.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle between the CPU run controller and the board/CPU side.
interface cpu_run_ctrl_if #(
   parameter int DIV_W = 26,
   parameter int PC_W  = 16,
   parameter int CNT_W = 16
);
   logic             i_step_key;
   logic             i_run;
   logic [DIV_W-1:0] i_rate_div;
   logic             i_bp_en;
   logic [PC_W-1:0]  i_bp_addr;
   logic [PC_W-1:0]  i_pc;
   logic             i_halt_inst;
   logic             o_cpu_ce;
   logic [1:0]       o_state;
   logic [CNT_W-1:0] o_step_cnt;
   logic             o_break;

   modport master (
      output i_step_key, i_run, i_rate_div, i_bp_en, i_bp_addr, i_pc, i_halt_inst,
      input  o_cpu_ce, o_state, o_step_cnt, o_break
   );

   modport slave (
      input  i_step_key, i_run, i_rate_div, i_bp_en, i_bp_addr, i_pc, i_halt_inst,
      output o_cpu_ce, o_state, o_step_cnt, o_break
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution controller: single-step / free-run clock-enable generator with PC breakpoint and halt stop.
//   state | meaning
//   IDLE  | waiting for run switch or debounced key press
//   STEP  | single pulse just issued, back to IDLE next cycle
//   RUN   | free-running, one pulse per prescaler period
//   BREAK | stopped on breakpoint or halt; key steps once and resumes
module cpu_run_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DIV_W           = 26,
   parameter int PC_W            = 16,
   parameter int CNT_W           = 16
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   cpu_run_ctrl_if.slave  bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_STEP  = 2'b01;
   localparam logic [1:0] S_RUN   = 2'b10;
   localparam logic [1:0] S_BREAK = 2'b11;

   logic             r_key_s1, r_key_s2, r_key_db, r_key_db_d;
   logic             r_run_s1, r_run_s2;
   logic [DB_W-1:0]  r_db_cnt;
   logic [DIV_W-1:0] r_presc, w_presc_nxt, w_div_m1;
   logic [1:0]       r_state, w_state_nxt;
   logic             r_ce, w_ce_nxt, r_brk;
   logic [CNT_W-1:0] r_step_cnt;
   logic             w_press, w_wrap, w_due, w_bp_hit;

   assign w_press  = r_key_db_d & ~r_key_db;
   assign w_div_m1 = (bus.i_rate_div == '0) ? '0 : bus.i_rate_div - DIV_W'(1);
   assign w_wrap   = (r_presc >= w_div_m1);
   // a pulse in flight suppresses the next one so CE never holds two cycles
   assign w_due    = w_wrap & ~r_ce;
   assign w_bp_hit = bus.i_bp_en && (bus.i_pc == bus.i_bp_addr);

   always_comb begin
      w_state_nxt = r_state;
      w_ce_nxt    = 1'b0;
      w_presc_nxt = '0;
      case (r_state)
         S_IDLE: begin
            if (r_run_s2) begin
               w_state_nxt = S_RUN;
            end else if (w_press) begin
               w_state_nxt = S_STEP;
               w_ce_nxt    = ~bus.i_halt_inst;
            end
         end
         S_STEP: w_state_nxt = S_IDLE;
         S_RUN: begin
            if (!r_run_s2) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_presc_nxt = w_wrap ? '0 : r_presc + DIV_W'(1);
               if (w_due) begin
                  if (w_bp_hit || bus.i_halt_inst) w_state_nxt = S_BREAK;
                  else                              w_ce_nxt    = 1'b1;
               end
            end
         end
         default: begin
            if (!r_run_s2) begin
               w_state_nxt = S_IDLE;
            end else if (w_press) begin
               w_state_nxt = S_RUN;
               w_ce_nxt    = ~bus.i_halt_inst;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key_s1   <= 1'b1;
         r_key_s2   <= 1'b1;
         r_key_db   <= 1'b1;
         r_key_db_d <= 1'b1;
         r_run_s1   <= 1'b0;
         r_run_s2   <= 1'b0;
         r_db_cnt   <= '0;
         r_presc    <= '0;
         r_state    <= S_IDLE;
         r_ce       <= 1'b0;
         r_brk      <= 1'b0;
         r_step_cnt <= '0;
      end else begin
         r_key_s1   <= bus.i_step_key;
         r_key_s2   <= r_key_s1;
         r_run_s1   <= bus.i_run;
         r_run_s2   <= r_run_s1;
         r_key_db_d <= r_key_db;
         if (r_key_s2 == r_key_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_cnt <= '0;
            r_key_db <= r_key_s2;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
         r_presc <= w_presc_nxt;
         r_state <= w_state_nxt;
         r_ce    <= w_ce_nxt;
         r_brk   <= (w_state_nxt == S_BREAK);
         if (w_ce_nxt) r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
   end

   assign bus.o_cpu_ce   = r_ce;
   assign bus.o_state    = r_state;
   assign bus.o_step_cnt = r_step_cnt;
   assign bus.o_break    = r_brk;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected pulses, a monitor checks each CE pulse.
module tb_cpu_run_ctrl;
   localparam int DB    = 4;
   localparam int DIV_W = 26;
   localparam int PC_W  = 16;
   localparam int CNT_W = 16;

   typedef struct { int cnt; int pc; int cyc; } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cpu_run_ctrl_if #(.DIV_W(DIV_W), .PC_W(PC_W), .CNT_W(CNT_W)) ifc();

   cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .DIV_W(DIV_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (ifc.slave)
   );

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          exp_cnt = 0;
   logic        prev_ce = 1'b0;
   logic [15:0] pc_base = '0;
   logic [15:0] pc_cnt;

   // CPU model: PC advances only on a CE pulse
   always @(posedge clk or negedge rst_n)
      if (!rst_n) pc_cnt <= '0;
      else if (ifc.o_cpu_ce) pc_cnt <= pc_cnt + 16'd1;
   assign ifc.i_pc = pc_base + pc_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         prev_ce = 1'b0;
      end else begin
         if (ifc.o_cpu_ce) begin
            check("ce_single_cycle", prev_ce, 0);
            check("ce_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("ce_step_cnt", ifc.o_step_cnt, e.cnt);
               check("ce_pc", ifc.i_pc, e.pc);
               if (e.cyc >= 0) check("ce_cycle", cyc, e.cyc);
            end
         end
         prev_ce = ifc.o_cpu_ce;
      end
   end

   task automatic expect_pulse(input int pc, input int c);
      exp_t e;
      exp_cnt++;
      e = '{exp_cnt, pc, c};
      sb.push_back(e);
   endtask

   task automatic press_key(input int low);
      @(negedge clk);
      ifc.i_step_key = 1'b0;
      repeat (low) @(negedge clk);
      ifc.i_step_key = 1'b1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
      #1;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_drained"}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int k, pc0;
      ifc.i_step_key  = 1'b1;
      ifc.i_run       = 1'b0;
      ifc.i_rate_div  = '0;
      ifc.i_bp_en     = 1'b0;
      ifc.i_bp_addr   = '0;
      ifc.i_halt_inst = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // idle after reset: no pulses at all (monitor flags any)
      repeat (100) @(negedge clk);
      #1;
      check("reset_state", ifc.o_state, 0);
      check("reset_cnt", ifc.o_step_cnt, 0);
      check("reset_break", ifc.o_break, 0);

      // 2-cycle bounce is rejected
      press_key(2);
      repeat (12) @(negedge clk);
      #1;
      check("bounce_cnt", ifc.o_step_cnt, exp_cnt);

      // clean press: exactly one pulse
      expect_pulse(int'(ifc.i_pc), -1);
      press_key(10);
      drain(20, "step");
      repeat (10) @(negedge clk);
      #1;
      check("step_cnt", ifc.o_step_cnt, 1);
      check("step_state", ifc.o_state, 0);

      // RUN, D=5: entry 3 cycles after drive (2 sync + FSM), first pulse 5 after entry
      @(negedge clk);
      k = cyc;
      pc0 = int'(ifc.i_pc);
      ifc.i_rate_div = 26'd5;
      ifc.i_run = 1'b1;
      for (int i = 0; i < 20; i++) expect_pulse(pc0 + i, k + 8 + 5 * i);
      drain(150, "run5");
      check("run5_state", ifc.o_state, 2);
      ifc.i_run = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("run5_stop_state", ifc.o_state, 0);
      check("run5_cnt", ifc.o_step_cnt, 21);

      // RUN, D=0 acts as 1: pulse every other cycle
      @(negedge clk);
      k = cyc;
      pc0 = int'(ifc.i_pc);
      ifc.i_rate_div = '0;
      ifc.i_run = 1'b1;
      for (int i = 0; i < 8; i++) expect_pulse(pc0 + i, k + 4 + 2 * i);
      wait_cyc(k + 16);
      ifc.i_run = 1'b0;
      drain(20, "div0");
      repeat (5) @(negedge clk);
      #1;
      check("div0_stop_state", ifc.o_state, 0);

      // breakpoint at PC 7, PC starts at 5, D=3
      pc_base = 16'd5 - pc_cnt;
      ifc.i_bp_en = 1'b1;
      ifc.i_bp_addr = 16'h0007;
      ifc.i_rate_div = 26'd3;
      @(negedge clk);
      k = cyc;
      ifc.i_run = 1'b1;
      expect_pulse(5, k + 6);
      expect_pulse(6, k + 9);
      wait_cyc(k + 16);
      check("bp_state", ifc.o_state, 3);
      check("bp_flag", ifc.o_break, 1);
      check("bp_pc", ifc.i_pc, 7);
      drain(2, "bp");

      // key in BREAK: one pulse at PC 7 past the breakpoint, then RUN continues
      expect_pulse(7, -1);
      expect_pulse(8, -1);
      press_key(8);
      drain(20, "bp_resume");
      check("bp_resume_state", ifc.o_state, 2);
      check("bp_resume_flag", ifc.o_break, 0);
      ifc.i_run = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("bp_stop_state", ifc.o_state, 0);
      ifc.i_bp_en = 1'b0;

      // halt: RUN stops in BREAK without a pulse; key in BREAK or IDLE gives none
      ifc.i_halt_inst = 1'b1;
      ifc.i_rate_div = 26'd2;
      @(negedge clk);
      ifc.i_run = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("halt_run_state", ifc.o_state, 3);
      press_key(8);
      repeat (8) @(negedge clk);
      #1;
      check("halt_break_state", ifc.o_state, 3);
      check("halt_break_cnt", ifc.o_step_cnt, exp_cnt);
      ifc.i_run = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("halt_idle_state", ifc.o_state, 0);
      press_key(8);
      repeat (8) @(negedge clk);
      #1;
      check("halt_step_cnt", ifc.o_step_cnt, exp_cnt);
      check("halt_step_state", ifc.o_state, 0);
      ifc.i_halt_inst = 1'b0;

      // rate lowered 10 -> 4 with prescaler at 5: due at once, then period 4
      @(negedge clk);
      k = cyc;
      pc0 = int'(ifc.i_pc);
      ifc.i_rate_div = 26'd10;
      ifc.i_run = 1'b1;
      expect_pulse(pc0, k + 9);
      expect_pulse(pc0 + 1, k + 13);
      wait_cyc(k + 8);
      ifc.i_rate_div = 26'd4;
      wait_cyc(k + 13);
      ifc.i_run = 1'b0;
      drain(5, "ratechg");
      repeat (5) @(negedge clk);
      #1;
      check("ratechg_stop_state", ifc.o_state, 0);

      // async reset while a pulse is high
      @(negedge clk);
      k = cyc;
      pc0 = int'(ifc.i_pc);
      ifc.i_rate_div = 26'd7;
      ifc.i_run = 1'b1;
      expect_pulse(pc0, k + 10);
      wait_cyc(k + 10);
      check("rst_pre_ce", ifc.o_cpu_ce, 1);
      rst_n = 1'b0;
      exp_cnt = 0;
      #1;
      check("rst_ce", ifc.o_cpu_ce, 0);
      check("rst_state", ifc.o_state, 0);
      check("rst_cnt", ifc.o_step_cnt, 0);
      check("rst_break", ifc.o_break, 0);
      ifc.i_run = 1'b0;
      drain(1, "rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("post_rst_state", ifc.o_state, 0);
      check("post_rst_cnt", ifc.o_step_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
